// File: rtl/bf_fetch_unit.sv
// Brainfuck instruction fetch/sequencer: owns the BCD instruction pointer, hands
// opcodes to the executor over valid/ack and resolves brackets by scanning the ROM.
module bf_fetch_unit #(
  parameter int portSize = 12,
  parameter int dataSize = 4,
  parameter int DEPTH_W  = 6
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Run,
  output logic [portSize-1:0] Address,
  input  logic [dataSize-1:0] RomData,
  output logic [dataSize-1:0] Instr,
  output logic                InstrValid,
  input  logic                InstrAck,
  input  logic                CellZero,
  output logic                Busy,
  output logic                Halted,
  output logic                Error
);
  localparam int DIGITS = portSize / 4;
  localparam logic [dataSize-1:0] OP_END   = dataSize'(4'b0000);
  localparam logic [dataSize-1:0] OP_OPEN  = dataSize'(4'b0110);
  localparam logic [dataSize-1:0] OP_CLOSE = dataSize'(4'b0111);

  typedef enum logic [2:0] {
    IDLE, FETCH, PRESENT, SEEK_FWD, SEEK_BWD, HALT, ERROR
  } state_e;

  state_e              state;
  logic [DEPTH_W-1:0]  depth;
  logic [portSize-1:0] ip_inc, ip_dec;
  logic                inc_ovf, dec_ovf;
  logic                rom_open, rom_close, cur_open, cur_close;
  logic                depth_full, depth_zero;
  logic                err_now;

  // Per-digit BCD step; the extra MSB is the carry/borrow out of the top digit.
  function automatic logic [portSize:0] bcd_step(input logic [portSize-1:0] v,
                                                 input logic up);
    logic [portSize-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (up) begin
          if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  assign {inc_ovf, ip_inc} = bcd_step(Address, 1'b1);
  assign {dec_ovf, ip_dec} = bcd_step(Address, 1'b0);

  assign rom_open   = (RomData == OP_OPEN);
  assign rom_close  = (RomData == OP_CLOSE);
  assign cur_open   = (Instr == OP_OPEN);
  assign cur_close  = (Instr == OP_CLOSE);
  assign depth_full = &depth;
  assign depth_zero = (depth == '0);

  // Any IP step that would leave 000..999, or nesting beyond the counter, traps.
  always_comb begin
    // NOTE: default first so every path assigns err_now and no latch is inferred.
    err_now = 1'b0;
    case (state)
      PRESENT:  if (InstrAck) err_now = (cur_close && !CellZero) ? dec_ovf : inc_ovf;
      SEEK_FWD: err_now = (rom_open && depth_full) || inc_ovf;
      SEEK_BWD: err_now = (rom_close && depth_full) ||
                          ((rom_open && depth_zero) ? inc_ovf : dec_ovf);
      default:  err_now = 1'b0;
    endcase
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch sees the pre-edge values of Address, Instr and depth.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      Address    <= '0;
      Instr      <= '0;
      InstrValid <= 1'b0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      Error      <= 1'b0;
      depth      <= '0;
    end else if (err_now) begin
      state      <= ERROR;
      Error      <= 1'b1;
      Busy       <= 1'b0;
      InstrValid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Run) begin
          state <= FETCH;
          Busy  <= 1'b1;
        end
        FETCH: begin
          Instr <= RomData;
          if (RomData == OP_END) begin
            state  <= HALT;
            Halted <= 1'b1;
            Busy   <= 1'b0;
          end else begin
            state      <= PRESENT;
            InstrValid <= 1'b1;
          end
        end
        PRESENT: if (InstrAck) begin
          InstrValid <= 1'b0;
          depth      <= '0;
          if (cur_close && !CellZero) begin
            Address <= ip_dec;
            state   <= SEEK_BWD;
          end else begin
            Address <= ip_inc;
            state   <= (cur_open && CellZero) ? SEEK_FWD : FETCH;
          end
        end
        SEEK_FWD: begin
          Address <= ip_inc;
          if (rom_open) depth <= depth + DEPTH_W'(1);
          else if (rom_close) begin
            if (depth_zero) state <= FETCH;
            else            depth <= depth - DEPTH_W'(1);
          end
        end
        SEEK_BWD: begin
          if (rom_open && depth_zero) begin
            Address <= ip_inc;
            state   <= FETCH;
          end else begin
            Address <= ip_dec;
            if (rom_close)     depth <= depth + DEPTH_W'(1);
            else if (rom_open) depth <= depth - DEPTH_W'(1);
          end
        end
        default: ;  // HALT and ERROR hold until reset
      endcase
    end
  end
endmodule

// File: tb/tb_bf_fetch_unit.sv
// Self-checking bench for bf_fetch_unit: directed step tables for the named
// programs plus random programs checked against an array-scanning reference model.
module tb_bf_fetch_unit;
  typedef enum int {K_NONE, K_PRES, K_HALT, K_ERR} kind_e;
  typedef struct {
    logic       cz;     // CellZero to give with the ack of this instruction
    kind_e      kind;   // what must be observed
    int         addr;   // decimal IP
    logic [3:0] instr;  // opcode when kind is K_PRES
    int         gap;    // cycles with nothing shown before it; -1 = don't care
  } step_t;

  localparam logic [3:0] OPEN  = 4'b0110;
  localparam logic [3:0] CLOSE = 4'b0111;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Run = 1'b0;
  logic        InstrAck = 1'b0;
  logic        CellZero = 1'b0;
  logic [11:0] Address;
  logic [3:0]  RomData, Instr;
  logic        InstrValid, Busy, Halted, Error;

  logic [3:0]  rom [0:999];
  int          rom_idx;
  logic        addr_ok;
  int          errors = 0;
  int          checks = 0;
  bit          bad_bcd = 1'b0;
  bit          noisy = 1'b0;

  always #5 Clk = ~Clk;

  bf_fetch_unit dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Address(Address), .RomData(RomData),
    .Instr(Instr), .InstrValid(InstrValid), .InstrAck(InstrAck),
    .CellZero(CellZero), .Busy(Busy), .Halted(Halted), .Error(Error)
  );

  function automatic int bcd2int(input logic [11:0] a);
    return int'(a[11:8]) * 100 + int'(a[7:4]) * 10 + int'(a[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  assign addr_ok = (Address[11:8] <= 4'd9) && (Address[7:4] <= 4'd9) && (Address[3:0] <= 4'd9);
  assign rom_idx = bcd2int(Address);
  assign RomData = addr_ok ? rom[rom_idx] : 4'hF;

  always @(negedge Clk) if (!Rst && !addr_ok) bad_bcd = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    Rst = 1'b0; Run = 1'b0; InstrAck = 1'b0; CellZero = 1'b0;
    #1 Rst = 1'b1;
    #1;
    check({tag, "/rst_addr"},   Address, 0);
    check({tag, "/rst_instr"},  Instr, 0);
    check({tag, "/rst_valid"},  InstrValid, 0);
    check({tag, "/rst_busy"},   Busy, 0);
    check({tag, "/rst_halted"}, Halted, 0);
    check({tag, "/rst_error"},  Error, 0);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic start;
    Run = 1'b1;
    tick;
    Run = 1'b0;
  endtask

  task automatic wait_event(output kind_e k, output int gap);
    gap = 0;
    k = K_NONE;
    while (gap <= 2000) begin
      if (Error)      begin k = K_ERR;  break; end
      if (Halted)     begin k = K_HALT; break; end
      if (InstrValid) begin k = K_PRES; break; end
      if (noisy) begin
        InstrAck = 1'($urandom_range(0, 1));
        Run      = 1'($urandom_range(0, 1));
      end
      gap++;
      tick;
    end
    InstrAck = 1'b0;
    Run = 1'b0;
  endtask

  task automatic observe(input string tag, input step_t e, output bit ok);
    kind_e k;
    int    gap;
    wait_event(k, gap);
    check({tag, "/kind"}, k, e.kind);
    check({tag, "/addr"}, Address, int2bcd(e.addr));
    if (e.kind == K_PRES) begin
      check({tag, "/instr"}, Instr, e.instr);
      check({tag, "/busy_hi"}, Busy, 1);
    end else begin
      check({tag, "/busy_lo"}, Busy, 0);
    end
    if (e.gap >= 0) check({tag, "/gap"}, gap, e.gap);
    ok = (k == e.kind);
  endtask

  task automatic ack(input logic cz, input int hold, input logic [3:0] instr);
    repeat (hold) begin
      tick;
      check("hold/valid", InstrValid, 1);
      check("hold/instr", Instr, instr);
    end
    InstrAck = 1'b1;
    CellZero = cz;
    if (noisy) Run = 1'($urandom_range(0, 1));
    tick;
    InstrAck = 1'b0;
    Run = 1'b0;
    CellZero = 1'($urandom_range(0, 1));
    check("ack/valid_drop", InstrValid, 0);
  endtask

  function automatic step_t mk(input logic cz, input kind_e k, input int addr,
                               input logic [3:0] instr, input int gap);
    step_t s;
    s.cz = cz; s.kind = k; s.addr = addr; s.instr = instr; s.gap = gap;
    return s;
  endfunction

  task automatic run_table(input string tag, input step_t tbl[$]);
    bit ok;
    start;
    for (int i = 0; i < tbl.size(); i++) begin
      observe($sformatf("%s[%0d]", tag, i), tbl[i], ok);
      if (!ok) break;
      if (tbl[i].kind == K_PRES) ack(tbl[i].cz, i % 2, tbl[i].instr);
    end
  endtask

  function automatic void load(input logic [3:0] prog[$]);
    for (int i = 0; i < 1000; i++) rom[i] = (i < prog.size()) ? prog[i] : 4'b0000;
  endfunction

  // Reference: what the executor sees after acking opcode op at decimal IP ip.
  function automatic step_t model_next(input int ip, input logic [3:0] op, input logic cz);
    bit    err;
    int    eaddr, nip, gap, d;
    step_t s;
    err = 1'b0; eaddr = 0; nip = 0; gap = 1; d = 0;
    if (op == OPEN && cz) begin
      err = 1'b1; eaddr = 999;
      for (int j = ip + 1; j <= 999; j++) begin
        if (rom[j] == OPEN) begin
          if (d == 63) begin eaddr = j; break; end
          d++;
        end else if (rom[j] == CLOSE) begin
          if (d == 0) begin
            if (j < 999) begin err = 1'b0; nip = j + 1; gap = j - ip + 1; end
            break;
          end
          d--;
        end
      end
    end else if (op == CLOSE && !cz) begin
      err = 1'b1; eaddr = 0;
      for (int j = ip - 1; j >= 0; j--) begin
        if (rom[j] == CLOSE) begin
          if (d == 63) begin eaddr = j; break; end
          d++;
        end else if (rom[j] == OPEN) begin
          if (d == 0) begin err = 1'b0; nip = j + 1; gap = ip - j + 1; break; end
          d--;
        end
      end
    end else if (ip == 999) begin
      err = 1'b1; eaddr = 999;
    end else begin
      nip = ip + 1;
    end
    if (err) s = mk(1'b0, K_ERR, eaddr, 4'b0000, -1);
    else     s = mk(1'b0, (rom[nip] == 4'b0000) ? K_HALT : K_PRES, nip, rom[nip], gap);
    return s;
  endfunction

  initial begin
    step_t      tbl[$];
    logic [3:0] prog[$];
    step_t      e;
    bit         ok;
    logic       cz;

    // "+ + . 0000": three plain hand-offs then halt.
    load('{4'b0010, 4'b0010, 4'b1000, 4'b0000});
    do_reset("t1");
    tbl = '{mk(0, K_PRES, 0, 4'b0010, 1), mk(0, K_PRES, 1, 4'b0010, 1),
            mk(0, K_PRES, 2, 4'b1000, 1), mk(0, K_HALT, 3, 4'b0000, 1)};
    run_table("plain", tbl);
    start;  // Run after HALT must not restart
    tick;
    check("halt_sticky/halted", Halted, 1);
    check("halt_sticky/addr", Address, int2bcd(3));

    // "[ + [ - ] > ] . 0000": forward seek over a nested pair.
    load('{OPEN, 4'b0010, OPEN, 4'b0011, CLOSE, 4'b0100, CLOSE, 4'b1000, 4'b0000});
    do_reset("t2");
    tbl = '{mk(1, K_PRES, 0, OPEN, 1), mk(0, K_PRES, 7, 4'b1000, 7),
            mk(0, K_HALT, 8, 4'b0000, 1)};
    run_table("seek_fwd", tbl);

    // "+ [ - ] 0000": '[' falls through, ']' loops back once, then exits.
    load('{4'b0010, OPEN, 4'b0011, CLOSE, 4'b0000});
    do_reset("t3");
    tbl = '{mk(0, K_PRES, 0, 4'b0010, 1), mk(0, K_PRES, 1, OPEN, 1),
            mk(0, K_PRES, 2, 4'b0011, 1), mk(0, K_PRES, 3, CLOSE, 1),
            mk(0, K_PRES, 2, 4'b0011, 3), mk(1, K_PRES, 3, CLOSE, 1),
            mk(0, K_HALT, 4, 4'b0000, 1)};
    run_table("seek_bwd", tbl);

    // "[ + 0000": unmatched forward seek runs off the top of the ROM.
    load('{OPEN, 4'b0010, 4'b0000});
    do_reset("t4");
    tbl = '{mk(1, K_PRES, 0, OPEN, 1), mk(0, K_ERR, 999, 4'b0000, -1)};
    run_table("unmatched_fwd", tbl);

    // ']' at 000 with a non-zero cell needs a decrement below 000.
    load('{CLOSE});
    do_reset("t5");
    tbl = '{mk(0, K_PRES, 0, CLOSE, 1), mk(0, K_ERR, 0, 4'b0000, 0)};
    run_table("underflow", tbl);

    // BCD carry chain across 009->010, 099->100 and overflow at 999.
    for (int i = 0; i < 1000; i++) rom[i] = 4'b0010;
    rom[10] = 4'b1000;
    rom[100] = 4'b1000;
    do_reset("t6");
    start;
    for (int i = 0; i < 1000; i++) begin
      observe("bcd", mk(0, K_PRES, i, rom[i], 1), ok);
      if (!ok) break;
      ack(1'b0, 0, rom[i]);
    end
    observe("bcd_ovf", mk(0, K_ERR, 999, 4'b0000, 0), ok);

    // Reset mid forward seek, then restart from 000.
    load('{OPEN, 4'b0010, OPEN, 4'b0011, CLOSE, 4'b0100, CLOSE, 4'b1000, 4'b0000});
    do_reset("t7");
    start;
    observe("mid_seek/pre", mk(0, K_PRES, 0, OPEN, 1), ok);
    ack(1'b1, 0, OPEN);
    tick;
    check("mid_seek/seeking", {Busy, InstrValid}, 2'b10);
    do_reset("mid_seek");
    start;
    observe("mid_seek/restart", mk(0, K_PRES, 0, OPEN, 1), ok);

    // Reset while an instruction is presented.
    load('{4'b0010, 4'b0101, 4'b0000});
    do_reset("t8");
    start;
    observe("mid_pres/a", mk(0, K_PRES, 0, 4'b0010, 1), ok);
    ack(1'b0, 0, 4'b0010);
    observe("mid_pres/b", mk(0, K_PRES, 1, 4'b0101, 1), ok);
    do_reset("mid_pres");
    start;
    observe("mid_pres/restart", mk(0, K_PRES, 0, 4'b0010, 1), ok);

    // Random programs with spurious Run/ack against the reference model.
    noisy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      prog.delete();
      for (int i = 0; i < $urandom_range(5, 40); i++) begin
        case ($urandom_range(0, 9))
          0, 1:    prog.push_back(4'b0010);
          2:       prog.push_back(4'b0011);
          3:       prog.push_back(4'b0100);
          4:       prog.push_back(4'b0101);
          5:       prog.push_back(4'b1000);
          6:       prog.push_back(OPEN);
          7:       prog.push_back(CLOSE);
          8:       prog.push_back(4'b0001);
          default: prog.push_back(4'b1111);
        endcase
      end
      load(prog);
      do_reset("rand");
      start;
      e = mk(0, (rom[0] == 4'b0000) ? K_HALT : K_PRES, 0, rom[0], 1);
      for (int s = 0; s < 60; s++) begin
        observe($sformatf("rand%0d.%0d", p, s), e, ok);
        if (!ok || e.kind != K_PRES) break;
        cz = 1'($urandom_range(0, 1));
        ack(cz, $urandom_range(0, 2), e.instr);
        e = model_next(e.addr, e.instr, cz);
      end
    end
    noisy = 1'b0;

    check("bcd_digits_valid", bad_bcd, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
